// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
//   seq_state_t : sequencer FSM state encoding
//   cnt_width() : bit width needed to count 0 .. n-1 (minimum 1 bit)
package pll_reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Multi-flop synchroniser for a single asynchronous level into clk.
//   clk  : destination clock
//   rst  : synchronous active-high reset, clears every stage
//   din  : asynchronous input
//   dout : synchronised output (last flop of the chain)
module reset_seq_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the SoC in reset until PLL lock is stable and the button is released,
// then releases NUM_DOMAINS resets in order, bit 0 first.
//   clk_i          : PLL output clock
//   rst_i          : synchronous active-high reset
//   pll_locked_i   : PLL LOCKED flag (asynchronous)
//   ext_rst_i      : reset button, active-high, asynchronous and bouncy
//   rst_o          : staged active-high resets
//   ready_o        : all domains released
//   lock_lost_o    : one-cycle pulse when lock drops in RELEASE/RUN
//   relock_count_o : saturating count of lock-loss events
module pll_reset_sequencer
    import pll_reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned LOCK_HOLD_CYCLES = 1024,
    parameter int unsigned STAGE_GAP        = 16,
    parameter int unsigned NUM_DOMAINS      = 3,
    parameter int unsigned DEBOUNCE_CYCLES  = 65536
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pll_locked_i,
    input  logic                   ext_rst_i,
    output logic [NUM_DOMAINS-1:0] rst_o,
    output logic                   ready_o,
    output logic                   lock_lost_o,
    output logic [7:0]             relock_count_o
);

    localparam int unsigned HOLD_W = cnt_width(LOCK_HOLD_CYCLES);
    localparam int unsigned GAP_W  = cnt_width(STAGE_GAP);
    localparam int unsigned IDX_W  = cnt_width(NUM_DOMAINS);
    localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);

    logic locked_s;
    logic btn_s;
    logic btn_db;
    logic [DB_W-1:0] db_cnt;
    logic fault;

    seq_state_t state;
    seq_state_t state_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [IDX_W-1:0]  idx;
    logic hold_last;
    logic gap_last;
    logic idx_last;

    logic [NUM_DOMAINS-1:0] rst_d;
    logic ready_d;
    logic lost_d;

    reset_seq_sync #(.STAGES(SYNC_STAGES)) u_sync_locked (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (pll_locked_i),
        .dout (locked_s)
    );

    reset_seq_sync #(.STAGES(SYNC_STAGES)) u_sync_btn (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (ext_rst_i),
        .dout (btn_s)
    );

    // Button debounce: flip only after DEBOUNCE_CYCLES consecutive disagreements.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s != btn_db) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign fault     = !locked_s || btn_db;
    assign hold_last = (hold_cnt == HOLD_W'(LOCK_HOLD_CYCLES - 1));
    assign gap_last  = (gap_cnt == GAP_W'(STAGE_GAP - 1));
    assign idx_last  = (idx == IDX_W'(NUM_DOMAINS - 1));

    // State register plus counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= WAIT_LOCK;
            hold_cnt       <= '0;
            gap_cnt        <= '0;
            idx            <= '0;
            rst_o          <= '1;
            ready_o        <= 1'b0;
            lock_lost_o    <= 1'b0;
            relock_count_o <= 8'd0;
        end else begin
            state       <= state_nx;
            rst_o       <= rst_d;
            ready_o     <= ready_d;
            lock_lost_o <= lost_d;
            if (lost_d && (relock_count_o != 8'hFF)) begin
                relock_count_o <= relock_count_o + 8'd1;
            end
            hold_cnt <= (state == HOLD) ? hold_cnt + HOLD_W'(1) : '0;
            if (state == RELEASE) begin
                if (gap_last) begin
                    gap_cnt <= '0;
                    idx     <= idx + IDX_W'(1);
                end else begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
            end else begin
                gap_cnt <= '0;
                idx     <= '0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            WAIT_LOCK: if (!fault) state_nx = HOLD;
            HOLD: begin
                if (fault)          state_nx = WAIT_LOCK;
                else if (hold_last) state_nx = RELEASE;
            end
            RELEASE: begin
                if (fault)                     state_nx = WAIT_LOCK;
                else if (gap_last && idx_last) state_nx = RUN;
            end
            RUN: if (fault) state_nx = WAIT_LOCK;
            default: state_nx = WAIT_LOCK;
        endcase
    end

    // Next values for the registered outputs; a fault always beats a release.
    always_comb begin
        rst_d   = rst_o;
        ready_d = ready_o;
        lost_d  = 1'b0;
        case (state)
            WAIT_LOCK, HOLD: begin
                rst_d   = '1;
                ready_d = 1'b0;
            end
            RELEASE, RUN: begin
                if (fault) begin
                    rst_d   = '1;
                    ready_d = 1'b0;
                    lost_d  = !locked_s;
                end else if ((state == RELEASE) && gap_last) begin
                    for (int k = 0; k < NUM_DOMAINS; k++) begin
                        if (idx == IDX_W'(k)) rst_d[k] = 1'b0;
                    end
                    ready_d = idx_last;
                end
            end
            default: begin
                rst_d   = '1;
                ready_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;

    logic       clk_i;
    logic       rst_i;
    logic       pll_locked_i;
    logic       ext_rst_i;
    logic [2:0] rst_o;
    logic       ready_o;
    logic       lock_lost_o;
    logic [7:0] relock_count_o;

    int unsigned assert_count;
    int unsigned fail_count;

    pll_reset_sequencer #(
        .SYNC_STAGES      (2),
        .LOCK_HOLD_CYCLES (8),
        .STAGE_GAP        (4),
        .NUM_DOMAINS      (3),
        .DEBOUNCE_CYCLES  (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pll_locked_i   (pll_locked_i),
        .ext_rst_i      (ext_rst_i),
        .rst_o          (rst_o),
        .ready_o        (ready_o),
        .lock_lost_o    (lock_lost_o),
        .relock_count_o (relock_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance n clock edges, then settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One-edge reset pulse with lock and button low; returns right after the reset edge.
    task automatic pulse_reset();
        rst_i        = 1'b1;
        pll_locked_i = 1'b0;
        ext_rst_i    = 1'b0;
        tick(1);
        rst_i = 1'b0;
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        rst_i        = 1'b1;
        pll_locked_i = 1'b0;
        ext_rst_i    = 1'b0;
        tick(3);
        check_eq("reset_rst_o", 32'(rst_o), 32'h7);
        check_eq("reset_ready", 32'(ready_o), 32'h0);
        check_eq("reset_lost", 32'(lock_lost_o), 32'h0);
        check_eq("reset_relock", 32'(relock_count_o), 32'h0);
        rst_i = 1'b0;

        // 1: lock at cycle 10 -> releases at 25, 29, 33
        tick(10);
        pll_locked_i = 1'b1;
        tick(14);
        check_eq("t1_c24_rst", 32'(rst_o), 32'h7);
        tick(1);
        check_eq("t1_c25_rst", 32'(rst_o), 32'h6);
        tick(3);
        check_eq("t1_c28_rst", 32'(rst_o), 32'h6);
        tick(1);
        check_eq("t1_c29_rst", 32'(rst_o), 32'h4);
        tick(3);
        check_eq("t1_c32_ready", 32'(ready_o), 32'h0);
        tick(1);
        check_eq("t1_c33_rst", 32'(rst_o), 32'h0);
        check_eq("t1_c33_ready", 32'(ready_o), 32'h1);

        // 2: lock glitch during HOLD restarts the hold window
        pulse_reset();
        tick(2);
        pll_locked_i = 1'b1;
        tick(5);
        pll_locked_i = 1'b0;
        tick(1);
        pll_locked_i = 1'b1;
        tick(14);
        check_eq("t2_pre_release", 32'(rst_o), 32'h7);
        tick(1);
        check_eq("t2_release0", 32'(rst_o), 32'h6);
        check_eq("t2_relock", 32'(relock_count_o), 32'h0);
        tick(8);
        check_eq("t2_ready", 32'(ready_o), 32'h1);

        // 3: lock loss in RUN
        pll_locked_i = 1'b0;
        tick(2);
        check_eq("t3_still_run", 32'(rst_o), 32'h0);
        tick(1);
        check_eq("t3_rst", 32'(rst_o), 32'h7);
        check_eq("t3_ready", 32'(ready_o), 32'h0);
        check_eq("t3_lost", 32'(lock_lost_o), 32'h1);
        check_eq("t3_relock", 32'(relock_count_o), 32'h1);
        tick(1);
        check_eq("t3_lost_once", 32'(lock_lost_o), 32'h0);
        pll_locked_i = 1'b1;
        tick(15);
        check_eq("t3_rerelease0", 32'(rst_o), 32'h6);
        tick(8);
        check_eq("t3_reready", 32'(ready_o), 32'h1);

        // 4: bouncy button ignored, held button resets
        for (int i = 0; i < 10; i++) begin
            ext_rst_i = (i % 2 == 0);
            tick(2);
        end
        ext_rst_i = 1'b0;
        tick(6);
        check_eq("t4_bounce_rst", 32'(rst_o), 32'h0);
        check_eq("t4_bounce_ready", 32'(ready_o), 32'h1);
        ext_rst_i = 1'b1;
        tick(6);
        check_eq("t4_btn_pre", 32'(rst_o), 32'h0);
        tick(1);
        check_eq("t4_btn_rst", 32'(rst_o), 32'h7);
        check_eq("t4_btn_lost", 32'(lock_lost_o), 32'h0);
        check_eq("t4_btn_relock", 32'(relock_count_o), 32'h1);
        tick(1);
        check_eq("t4_btn_lost2", 32'(lock_lost_o), 32'h0);
        ext_rst_i = 1'b0;
        tick(18);
        check_eq("t4_rel_pre", 32'(rst_o), 32'h7);
        tick(1);
        check_eq("t4_rel0", 32'(rst_o), 32'h6);

        // 5: rst_i mid-RELEASE
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check_eq("t5_rst", 32'(rst_o), 32'h7);
        check_eq("t5_ready", 32'(ready_o), 32'h0);
        check_eq("t5_relock", 32'(relock_count_o), 32'h0);
        tick(14);
        check_eq("t5_pre", 32'(rst_o), 32'h7);
        tick(1);
        check_eq("t5_rel0", 32'(rst_o), 32'h6);
        tick(8);
        check_eq("t5_ready_again", 32'(ready_o), 32'h1);

        // 6: 256 lock losses, each landing on a release edge
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            pll_locked_i = 1'b1;
            tick(12);
            pll_locked_i = 1'b0;
            tick(3);
            if (i == 0 || i == 255) begin
                check_eq("t6_fault_wins", 32'(rst_o), 32'h7);
                check_eq("t6_lost", 32'(lock_lost_o), 32'h1);
            end
            if (i == 254) check_eq("t6_cnt255", 32'(relock_count_o), 32'd255);
            if (i == 0)   check_eq("t6_cnt1", 32'(relock_count_o), 32'd1);
            tick(1);
        end
        check_eq("t6_saturated", 32'(relock_count_o), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
